// File: rtl/tcam_pkg.sv
// Shared sizing constants for the 16x16 ternary CAM.
package tcam_pkg;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
endpackage

// File: rtl/tcam_match_cell.sv
// One TCAM entry: stored value, don't-care mask, valid bit and match line.
module tcam_match_cell
  import tcam_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [WIDTH-1:0] key,
  output logic             match
);

  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             valid_q, valid_d;

  always_comb begin
    value_d = value_q;
    mask_d  = mask_q;
    valid_d = valid_q;
    if (we) begin
      value_d = wdata;
      mask_d  = wmask;
      valid_d = 1'b1;
    end
  end

  // Contents are don't-care until valid, so they carry no reset.
  always_ff @(posedge clk) begin
    value_q <= value_d;
    mask_q  <= mask_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  assign match = valid_q &&
    (((value_q ^ key) & ~mask_q) == '0);

endmodule

// File: rtl/tcam.sv
// 16-entry ternary CAM: write decoder, parallel match cells,
// lowest-index priority encoder and registered search result.
module tcam
  import tcam_pkg::*;
(
  input  logic             clk,
  input  logic             resetN,
  output logic [AW-1:0]    found_address,
  output logic             found_any,
  input  logic [WIDTH-1:0] data,
  input  logic             write_readN,
  input  logic [WIDTH-1:0] dontcare,
  input  logic [AW-1:0]    write_address
);

  logic             rst;
  logic [DEPTH-1:0] we_vec;
  logic [DEPTH-1:0] match_vec;
  logic [AW-1:0]    enc_addr;
  logic             enc_any;

  logic [AW-1:0]    addr_q, addr_d;
  logic             any_q, any_d;

  // The port name suggests active-low, but reset asserts on 1.
  assign rst = resetN;

  always_comb begin
    we_vec = '0;
    if (write_readN) we_vec[write_address] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    tcam_match_cell u_cell (
      .clk   (clk),
      .rst   (rst),
      .we    (we_vec[g]),
      .wdata (data),
      .wmask (dontcare),
      .key   (data),
      .match (match_vec[g])
    );
  end

  // Scan downward so the lowest matching index wins.
  always_comb begin
    enc_addr = '0;
    enc_any  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        enc_addr = AW'(i);
        enc_any  = 1'b1;
      end
    end
  end

  always_comb begin
    addr_d = addr_q;
    any_d  = any_q;
    if (!write_readN) begin
      addr_d = enc_addr;
      any_d  = enc_any;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      any_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      any_q  <= any_d;
    end
  end

  assign found_address = addr_q;
  assign found_any     = any_q;

endmodule

// File: tb/tb_tcam.sv
// Self-checking bench for tcam: array model checked every cycle
// plus directed searches with hand-computed results.
module tb_tcam;
  import tcam_pkg::*;

  logic             clk = 1'b0;
  logic             resetN;
  logic [AW-1:0]    found_address;
  logic             found_any;
  logic [WIDTH-1:0] data;
  logic             write_readN;
  logic [WIDTH-1:0] dontcare;
  logic [AW-1:0]    write_address;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  tcam dut (
    .clk           (clk),
    .resetN        (resetN),
    .found_address (found_address),
    .found_any     (found_any),
    .data          (data),
    .write_readN   (write_readN),
    .dontcare      (dontcare),
    .write_address (write_address)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays, searched by a loop.
  logic [WIDTH-1:0] m_val [DEPTH];
  logic [WIDTH-1:0] m_msk [DEPTH];
  bit               m_vld [DEPTH];
  logic [AW-1:0]    exp_addr;
  logic             exp_any;

  always @(posedge clk or posedge resetN) begin
    if (resetN) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      exp_addr <= '0;
      exp_any  <= 1'b0;
    end else if (write_readN) begin
      m_val[write_address] = data;
      m_msk[write_address] = dontcare;
      m_vld[write_address] = 1'b1;
    end else begin
      logic          hit;
      logic [AW-1:0] a;
      hit = 1'b0;
      a   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (!hit && m_vld[i] &&
            (((m_val[i] ^ data) & ~m_msk[i]) == '0)) begin
          hit = 1'b1;
          a   = AW'(i);
        end
      end
      exp_any  <= hit;
      exp_addr <= a;
    end
  end

  task automatic check(input string name,
                       input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      check("model_any", int'(found_any), int'(exp_any));
      check("model_addr", int'(found_address), int'(exp_addr));
    end
  end

  task automatic do_write(input logic [AW-1:0] a,
                          input logic [WIDTH-1:0] d,
                          input logic [WIDTH-1:0] m);
    @(negedge clk);
    write_readN   = 1'b1;
    write_address = a;
    data          = d;
    dontcare      = m;
    @(posedge clk);
    #1;
  endtask

  task automatic do_search(input string name,
                           input logic [WIDTH-1:0] k,
                           input logic e_any,
                           input logic [AW-1:0] e_addr);
    @(negedge clk);
    write_readN = 1'b0;
    data        = k;
    dontcare    = '0;
    @(posedge clk);
    #1;
    check({name, "_any"}, int'(found_any), int'(e_any));
    check({name, "_addr"}, int'(found_address), int'(e_addr));
  endtask

  initial begin
    resetN        = 1'b1;
    write_readN   = 1'b0;
    data          = '0;
    dontcare      = '0;
    write_address = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_any", int'(found_any), 0);
    check("reset_addr", int'(found_address), 0);
    armed = 1'b1;
    @(negedge clk);
    resetN = 1'b0;

    do_search("empty", 16'h0000, 1'b0, 4'd0);

    do_write(4'd12, 16'b0110111011101010, 16'b1000011110000111);
    do_write(4'd8,  16'b1000010011001001, 16'b0011111111111111);
    do_search("k1", 16'b0110111001101110, 1'b1, 4'd12);
    do_search("k2", 16'b1110100101101100, 1'b1, 4'd12);
    do_search("k3", 16'b1001001010110101, 1'b1, 4'd8);
    do_search("k4", 16'h0001, 1'b0, 4'd0);

    do_write(4'd12, 16'h0000, 16'h0000);
    do_search("ovw_old", 16'b0110111001101110, 1'b0, 4'd0);
    do_search("ovw_new", 16'h0000, 1'b1, 4'd12);

    do_write(4'd3, 16'h1234, 16'hFFFF);
    do_write(4'd9, 16'h5678, 16'hFFFF);
    do_search("multi", 16'hABCD, 1'b1, 4'd3);

    do_write(4'd5, 16'hFFFF, 16'h0000);
    check("hold_any", int'(found_any), 1);
    check("hold_addr", int'(found_address), 3);
    do_search("wr_then_rd", 16'hFFFF, 1'b1, 4'd3);

    @(posedge clk);
    #3;
    resetN = 1'b1;
    #1;
    check("async_any", int'(found_any), 0);
    check("async_addr", int'(found_address), 0);
    @(negedge clk);
    resetN = 1'b0;
    do_search("post_rst", 16'h0000, 1'b0, 4'd0);
    do_search("post_rst2", 16'hABCD, 1'b0, 4'd0);

    do_write(4'd15, 16'hA5A5, 16'h00FF);
    do_search("last", 16'hA500, 1'b1, 4'd15);

    @(negedge clk);
    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
